// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sched_pkg
// Description : Shared types and result-word field layout for the ADC scan
//               scheduler (FSM state encoding, MCP300x word offsets).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_sched_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_IDLE = 3'd1,
    ST_TRIG = 3'd2,
    ST_CONV = 3'd3,
    ST_OUT  = 3'd4,
    ST_ACK  = 3'd5
  } sched_state_e;

  // MCP300x result word: [15] single-ended flag, [14:12] channel,
  // [11:10] must be zero, [9:0] conversion value.
  localparam int WORD_W  = 16;
  localparam int SGL_BIT = 15;
  localparam int CH_MSB  = 14;
  localparam int CH_LSB  = 12;
  localparam int PAD_MSB = 11;
  localparam int PAD_LSB = 10;
  localparam int CH_W    = CH_MSB - CH_LSB + 1;
  localparam int DATA_W  = 10;

  // Channel the scan should produce after 'ch', wrapping at 'n'.
  function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] ch,
                                                   input int unsigned    n);
    return CH_W'((32'(ch) + 32'd1) % n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_scheduler_if
// Description : ADC-interface handshake plus downstream result stream.
//               master = scheduler side, slave = ADC interface / consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_scan_scheduler_if;
  import adc_sched_pkg::*;

  logic                adc_sample;
  logic                adc_busy;
  logic [WORD_W-1:0]   adc_dout_reg;
  logic                adc_dout_avail;
  logic                adc_dout_accept;

  logic                res_valid;
  logic                res_ready;
  logic [CH_W-1:0]     res_channel;
  logic [DATA_W-1:0]   res_data;

  modport master (
    output adc_sample, adc_dout_accept, res_valid, res_channel, res_data,
    input  adc_busy, adc_dout_reg, adc_dout_avail, res_ready
  );

  modport slave (
    input  adc_sample, adc_dout_accept, res_valid, res_channel, res_data,
    output adc_busy, adc_dout_reg, adc_dout_avail, res_ready
  );
endinterface
`default_nettype wire

// File: rtl/adc_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_tick_gen
// Description : Sample-period counter with a one-deep pending flag and a
//               saturating count of ticks that arrived while one was pending.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_tick_gen #(
  parameter int PERIOD_W = 16,
  parameter int OVR_W    = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                enable_i,
  input  wire logic [PERIOD_W-1:0] period_i,
  input  wire logic                clear_i,
  output logic                     tick_pending_o,
  output logic                     en_rise_o,
  output logic [OVR_W-1:0]         overrun_count_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pending_q, pending_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;
  logic                enable_q;
  logic [PERIOD_W-1:0] last_cnt;
  logic                tick;
  logic                en_rise;

  // A period of zero behaves as one; '>=' also recovers if period shrinks mid-count.
  assign last_cnt = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
  assign tick     = enable_i && (cnt_q >= last_cnt);
  assign en_rise  = enable_i && !enable_q;

  // Next-state for counter, pending flag and overrun counter.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    if (!enable_i) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      cnt_d     = tick ? '0 : cnt_q + PERIOD_W'(1);
      pending_d = tick | (pending_q & ~clear_i);
      // A tick landing on a still-pending request is dropped and counted.
      if (tick && pending_q && !clear_i && (ovr_q != '1)) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end
    if (en_rise) begin
      ovr_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ovr_q     <= '0;
      enable_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      enable_q  <= enable_i;
    end
  end

  assign tick_pending_o  = pending_q;
  assign en_rise_o       = en_rise;
  assign overrun_count_o = ovr_q;

endmodule
`default_nettype wire

// File: rtl/adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_scheduler
// Description : Triggers MCP300x conversions at a programmable rate, forwards
//               each result word downstream, checks channel order and keeps
//               the latest value per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int PERIOD_W     = 16,
  parameter int OVR_W        = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       enable_i,
  input  wire logic [PERIOD_W-1:0]        period_i,
  adc_scan_scheduler_if.master            bus,
  output logic [NUM_CHANNELS*DATA_W-1:0]  latest_data_o,
  output logic                            seq_error_o,
  output logic [OVR_W-1:0]                overrun_count_o
);

  sched_state_e      state_q;
  logic              adc_sample_q;
  logic              accept_q;
  logic              res_valid_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [DATA_W-1:0] res_data_q;
  logic              exp_valid_q;
  logic [CH_W-1:0]   exp_ch_q;
  logic              seq_err_q;

  logic              tick_pending;
  logic              en_rise;
  logic              clear_pending;
  logic              capture;
  logic [CH_W-1:0]   word_ch;
  logic [DATA_W-1:0] word_data;
  logic              frame_err;

  assign word_ch       = bus.adc_dout_reg[CH_MSB:CH_LSB];
  assign word_data     = bus.adc_dout_reg[DATA_W-1:0];
  assign frame_err     = !bus.adc_dout_reg[SGL_BIT] ||
                         (bus.adc_dout_reg[PAD_MSB:PAD_LSB] != 2'b00);
  assign capture       = (state_q == ST_CONV) && bus.adc_dout_avail;
  // The request is consumed the moment the ADC acknowledges the trigger.
  assign clear_pending = (state_q == ST_TRIG) && bus.adc_busy;

  adc_tick_gen #(
    .PERIOD_W (PERIOD_W),
    .OVR_W    (OVR_W)
  ) u_tick (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable_i),
    .period_i        (period_i),
    .clear_i         (clear_pending),
    .tick_pending_o  (tick_pending),
    .en_rise_o       (en_rise),
    .overrun_count_o (overrun_count_o)
  );

  // Conversion sequencer with registered handshake outputs and order check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      adc_sample_q <= 1'b0;
      accept_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_data_q   <= '0;
      exp_valid_q  <= 1'b0;
      exp_ch_q     <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      case (state_q)
        // Drain any word the interface was holding when reset hit.
        ST_SYNC: begin
          accept_q <= bus.adc_dout_avail;
          if (!bus.adc_busy) begin
            accept_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (enable_i && tick_pending) begin
            adc_sample_q <= 1'b1;
            state_q      <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          if (bus.adc_busy) begin
            adc_sample_q <= 1'b0;
            state_q      <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bus.adc_dout_avail) begin
            res_ch_q    <= word_ch;
            res_data_q  <= word_data;
            res_valid_q <= 1'b1;
            if (frame_err || (exp_valid_q && (word_ch != exp_ch_q))) begin
              seq_err_q <= 1'b1;
            end
            exp_ch_q    <= next_channel(word_ch, NUM_CHANNELS);
            exp_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end
        end
        // Accept is withheld until downstream takes the result, stalling the ADC.
        ST_OUT: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            accept_q    <= 1'b1;
            state_q     <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus.adc_dout_avail) begin
            accept_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
      // A fresh enable means the next result re-establishes the reference.
      if (en_rise) begin
        exp_valid_q <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_bank
    logic [DATA_W-1:0] val_q;

    // Latest value for this channel, refreshed on every capture of it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        val_q <= '0;
      end else if (capture && (word_ch == CH_W'(gi))) begin
        val_q <= word_data;
      end
    end

    assign latest_data_o[gi*DATA_W +: DATA_W] = val_q;
  end

  assign bus.adc_sample      = adc_sample_q;
  assign bus.adc_dout_accept = accept_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_channel     = res_ch_q;
  assign bus.res_data        = res_data_q;
  assign seq_error_o         = seq_err_q;

endmodule
`default_nettype wire
